// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, forwarding select codes and MDU tracker state encoding
// for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 32;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        MDU_RUN  = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Register 0 is hard-wired, so it can never create a dependency.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] a,
                                       input logic [REG_ADDR_W-1:0] b);
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_tracker.sv
// Tracks the multi-cycle mul/div unit: busy for exactly MDU_LATENCY cycles
// after an accepted start; starts while busy are ignored.
module mdu_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o
);

    mdu_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MDU_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_RUN: begin
                if (start_i) begin
                    state_d = MDU_BUSY;
                    cnt_d   = 4'(MDU_LATENCY - 1);
                end
            end
            MDU_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MDU_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MDU_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = rst && (state_q == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch/MDU stalls, decode flush,
// EX and ID forwarding selects, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WIDTH       = STALL_CNT_W,
    parameter int MDU_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_decode,
    input  logic [REG_ADDR_W-1:0] rt_decode,
    input  logic [REG_ADDR_W-1:0] rs_execute,
    input  logic [REG_ADDR_W-1:0] rt_execute,
    input  logic [REG_ADDR_W-1:0] wa_execute,
    input  logic [REG_ADDR_W-1:0] wa_memory,
    input  logic [REG_ADDR_W-1:0] wa_writeback,
    input  logic                  reg_write_execute,
    input  logic                  reg_write_memory,
    input  logic                  reg_write_writeback,
    input  logic                  mem_to_reg_execute,
    input  logic                  mem_to_reg_memory,
    input  logic                  branch_decode,
    input  logic                  jump_decode,
    input  logic                  pc_src_decode,
    input  logic                  mdu_use_decode,
    input  logic                  mdu_start_execute,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  flush_decode,
    output logic                  flush_execute,
    output logic                  forward_a_decode,
    output logic                  forward_b_decode,
    output logic [1:0]            forward_a_execute,
    output logic [1:0]            forward_b_execute,
    output logic                  mdu_busy,
    output logic [WIDTH-1:0]      stall_cycles
);

    logic             lw_stall, br_stall, mdu_stall, stall;
    logic [WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    mdu_tracker #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_tracker (
        .clk     (clk),
        .rst     (rst),
        .start_i (mdu_start_execute),
        .busy_o  (mdu_busy)
    );

    always_comb begin
        lw_stall  = mem_to_reg_execute &&
                    (reg_match(wa_execute, rs_decode) || reg_match(wa_execute, rt_decode));
        // A branch compares in ID, so it must wait for any EX result and for a MEM load.
        br_stall  = branch_decode &&
                    ((reg_write_execute &&
                      (reg_match(wa_execute, rs_decode) || reg_match(wa_execute, rt_decode))) ||
                     (mem_to_reg_memory &&
                      (reg_match(wa_memory, rs_decode) || reg_match(wa_memory, rt_decode))));
        mdu_stall = mdu_busy && mdu_use_decode;
        stall     = rst && (lw_stall || br_stall || mdu_stall);
    end

    assign stall_fetch   = stall;
    assign stall_decode  = stall;
    assign flush_execute = stall;
    assign flush_decode  = rst && (pc_src_decode || jump_decode) && !stall;

    assign forward_a_decode = rst && reg_write_memory && reg_match(wa_memory, rs_decode);
    assign forward_b_decode = rst && reg_write_memory && reg_match(wa_memory, rt_decode);

    always_comb begin
        forward_a_execute = FWD_NONE;
        forward_b_execute = FWD_NONE;
        if (rst) begin
            if (reg_write_memory && reg_match(wa_memory, rs_execute)) begin
                forward_a_execute = FWD_MEM;
            end else if (reg_write_writeback && reg_match(wa_writeback, rs_execute)) begin
                forward_a_execute = FWD_WB;
            end
            if (reg_write_memory && reg_match(wa_memory, rt_execute)) begin
                forward_b_execute = FWD_MEM;
            end else if (reg_write_writeback && reg_match(wa_writeback, rt_execute)) begin
                forward_b_execute = FWD_WB;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute;
    logic [4:0] wa_execute, wa_memory, wa_writeback;
    logic       reg_write_execute, reg_write_memory, reg_write_writeback;
    logic       mem_to_reg_execute, mem_to_reg_memory;
    logic       branch_decode, jump_decode, pc_src_decode;
    logic       mdu_use_decode, mdu_start_execute;
    logic       stall_fetch, stall_decode, flush_decode, flush_execute;
    logic       forward_a_decode, forward_b_decode;
    logic [1:0] forward_a_execute, forward_b_execute;
    logic       mdu_busy;
    logic [3:0] stall_cycles;

    typedef struct {
        string      name;
        logic [10:0] ctl;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl #(.WIDTH(4), .MDU_LATENCY(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rs_decode           (rs_decode),
        .rt_decode           (rt_decode),
        .rs_execute          (rs_execute),
        .rt_execute          (rt_execute),
        .wa_execute          (wa_execute),
        .wa_memory           (wa_memory),
        .wa_writeback        (wa_writeback),
        .reg_write_execute   (reg_write_execute),
        .reg_write_memory    (reg_write_memory),
        .reg_write_writeback (reg_write_writeback),
        .mem_to_reg_execute  (mem_to_reg_execute),
        .mem_to_reg_memory   (mem_to_reg_memory),
        .branch_decode       (branch_decode),
        .jump_decode         (jump_decode),
        .pc_src_decode       (pc_src_decode),
        .mdu_use_decode      (mdu_use_decode),
        .mdu_start_execute   (mdu_start_execute),
        .stall_fetch         (stall_fetch),
        .stall_decode        (stall_decode),
        .flush_decode        (flush_decode),
        .flush_execute       (flush_execute),
        .forward_a_decode    (forward_a_decode),
        .forward_b_decode    (forward_b_decode),
        .forward_a_execute   (forward_a_execute),
        .forward_b_execute   (forward_b_execute),
        .mdu_busy            (mdu_busy),
        .stall_cycles        (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic st, input logic fd, input logic fad,
                                       input logic fbd, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic busy);
        return {st, st, fd, st, fad, fbd, fa, fb, busy};
    endfunction

    task automatic clear_inputs();
        rs_decode = 0; rt_decode = 0; rs_execute = 0; rt_execute = 0;
        wa_execute = 0; wa_memory = 0; wa_writeback = 0;
        reg_write_execute = 0; reg_write_memory = 0; reg_write_writeback = 0;
        mem_to_reg_execute = 0; mem_to_reg_memory = 0;
        branch_decode = 0; jump_decode = 0; pc_src_decode = 0;
        mdu_use_decode = 0; mdu_start_execute = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [10:0] ctl, input logic [3:0] cnt);
        exp_t e;
        e.name = name;
        e.ctl  = ctl;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e   = exp_q.pop_front();
            act = {stall_fetch, stall_decode, flush_decode, flush_execute,
                   forward_a_decode, forward_b_decode, forward_a_execute,
                   forward_b_execute, mdu_busy};
            checks++;
            if (act !== e.ctl || stall_cycles !== e.cnt) begin
                errors++;
                $display("FAIL %s: ctl=%b cnt=%0d, required ctl=%b cnt=%0d",
                         e.name, act, stall_cycles, e.ctl, e.cnt);
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0;
        clear_inputs();

        // reset: hazardous inputs must be masked
        next_cycle();
        mem_to_reg_execute = 1; wa_execute = 8; rs_decode = 8;
        reg_write_memory = 1; wa_memory = 5; rs_execute = 5; pc_src_decode = 1;
        push("reset_masked", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd0);
        next_cycle();
        rst = 1'b1; clear_inputs();
        push("idle", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd0);

        // load-use, with a jump present that must not flush while stalled
        next_cycle();
        mem_to_reg_execute = 1; wa_execute = 8; rs_decode = 8; jump_decode = 1;
        push("load_use", mk(1, 0, 0, 0, 2'b00, 2'b00, 0), 4'd0);
        next_cycle();
        wa_execute = 0; rs_decode = 0;
        push("load_use_r0", mk(0, 1, 0, 0, 2'b00, 2'b00, 0), 4'd1);

        // EX forwarding priority
        next_cycle();
        clear_inputs();
        reg_write_memory = 1; wa_memory = 5; reg_write_writeback = 1; wa_writeback = 5;
        rs_execute = 5; rt_execute = 0;
        push("fwd_mem_wins", mk(0, 0, 0, 0, 2'b10, 2'b00, 0), 4'd1);
        next_cycle();
        reg_write_memory = 0;
        push("fwd_wb", mk(0, 0, 0, 0, 2'b01, 2'b00, 0), 4'd1);
        next_cycle();
        rs_execute = 7; rt_execute = 5;
        push("fwd_b_wb", mk(0, 0, 0, 0, 2'b00, 2'b01, 0), 4'd1);

        // branch operand hazards
        next_cycle();
        clear_inputs();
        branch_decode = 1; rs_decode = 9; reg_write_execute = 1; wa_execute = 9; pc_src_decode = 1;
        push("branch_ex_stall", mk(1, 0, 0, 0, 2'b00, 2'b00, 0), 4'd1);
        next_cycle();
        wa_execute = 3; reg_write_memory = 1; wa_memory = 9;
        push("branch_fwd_flush", mk(0, 1, 1, 0, 2'b00, 2'b00, 0), 4'd2);
        next_cycle();
        mem_to_reg_memory = 1; rt_decode = 9;
        push("branch_mem_load", mk(1, 0, 1, 1, 2'b00, 2'b00, 0), 4'd2);
        next_cycle();
        branch_decode = 0; pc_src_decode = 0;
        push("nonbranch_mem_load", mk(0, 0, 1, 1, 2'b00, 2'b00, 0), 4'd3);

        // MDU busy window, second start ignored
        next_cycle();
        clear_inputs();
        mdu_start_execute = 1;
        push("mdu_start", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd3);
        next_cycle();
        mdu_start_execute = 0; mdu_use_decode = 1;
        push("mdu_e0_stall", mk(1, 0, 0, 0, 2'b00, 2'b00, 1), 4'd3);
        next_cycle();
        mdu_use_decode = 0; mdu_start_execute = 1;
        push("mdu_e1_restart", mk(0, 0, 0, 0, 2'b00, 2'b00, 1), 4'd4);
        next_cycle();
        mdu_start_execute = 0;
        push("mdu_e2", mk(0, 0, 0, 0, 2'b00, 2'b00, 1), 4'd4);
        next_cycle();
        mdu_use_decode = 1;
        push("mdu_e3_stall", mk(1, 0, 0, 0, 2'b00, 2'b00, 1), 4'd4);
        next_cycle();
        push("mdu_e4_release", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd5);

        // reset in the middle of an MDU operation
        next_cycle();
        clear_inputs();
        mdu_start_execute = 1;
        push("mdu2_start", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd5);
        next_cycle();
        mdu_start_execute = 0;
        push("mdu2_e0", mk(0, 0, 0, 0, 2'b00, 2'b00, 1), 4'd5);
        next_cycle();
        rst = 1'b0; mdu_use_decode = 1; mem_to_reg_execute = 1; wa_execute = 4; rt_decode = 4;
        reg_write_writeback = 1; wa_writeback = 6; rt_execute = 6; jump_decode = 1;
        push("rst_mid_op", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd5);
        next_cycle();
        rst = 1'b1; clear_inputs(); mdu_use_decode = 1;
        push("after_rst", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd0);

        // saturation of the 4-bit stall counter
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            clear_inputs();
            mem_to_reg_execute = 1; wa_execute = 12; rt_decode = 12;
            push($sformatf("sat_%0d", i), mk(1, 0, 0, 0, 2'b00, 2'b00, 0),
                 (i > 15) ? 4'd15 : 4'(i));
        end
        next_cycle();
        clear_inputs();
        push("sat_hold", mk(0, 0, 0, 0, 2'b00, 2'b00, 0), 4'd15);

        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; the only source of stall/flush controls for the IF/ID, ID/EX and PC registers.
- Detects load-use and branch-operand hazards, generates EX-stage and decode-stage (branch compare) forwarding selects, and issues decode flushes on taken branches/jumps.
- Tracks the multi-cycle mul/div unit (MDU) with an internal FSM/counter and stalls dependent decode instructions until it completes.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- WIDTH, `WIDTH (32), width of stall counter.
- MDU_LATENCY, 4, number of cycles the MDU stays busy after a start; legal range 2..15.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low
- rs_decode, rt_decode  in  5  source register numbers in ID
- rs_execute, rt_execute  in  5  source register numbers in EX
- wa_execute, wa_memory, wa_writeback  in  5  destination register in EX/MEM/WB
- reg_write_execute, reg_write_memory, reg_write_writeback  in  1  destination-write enables
- mem_to_reg_execute, mem_to_reg_memory  in  1  instruction is a load
- branch_decode  in  1  ID holds a conditional branch
- jump_decode  in  1  ID holds a jump
- pc_src_decode  in  1  branch resolved taken in ID
- mdu_use_decode  in  1  ID holds mult/div/mfhi/mflo
- mdu_start_execute  in  1  EX launches an MDU operation this cycle
- stall_fetch, stall_decode  out  1  hold PC and IF/ID
- flush_decode  out  1  clear IF/ID
- flush_execute  out  1  insert bubble into ID/EX
- forward_a_decode, forward_b_decode  out  1  ID compare operand from MEM result
- forward_a_execute, forward_b_execute  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- mdu_busy  out  1  MDU FSM in BUSY
- stall_cycles  out  WIDTH  saturating count of cycles with stall_decode=1

Behaviour:
- Match(x,y) means x==y and x!=0; register 0 never hazards or forwards.
- Load-use: lw_stall = mem_to_reg_execute & (Match(wa_execute,rs_decode) | Match(wa_execute,rt_decode)).
- Branch stall: br_stall = branch_decode & ((reg_write_execute & match on wa_execute) | (mem_to_reg_memory & match on wa_memory)) against rs_decode/rt_decode.
- MDU stall: mdu_stall = mdu_busy & mdu_use_decode.
- stall = lw_stall | br_stall | mdu_stall. stall_fetch = stall_decode = stall. flush_execute = stall.
- flush_decode = (pc_src_decode | jump_decode) & ~stall; a stalled branch never flushes.
- forward_a_execute: 10 if reg_write_memory & Match(wa_memory,rs_execute), else 01 if reg_write_writeback & Match(wa_writeback,rs_execute), else 00. MEM beats WB. B is identical on rt_execute.
- forward_a/b_decode = reg_write_memory & Match(wa_memory, rs/rt_decode).
- All of the above are combinational, same cycle as the inputs.
- MDU FSM, registered, 4-bit counter cnt:
  - RUN: mdu_start_execute -> BUSY, cnt <= MDU_LATENCY-1.
  - BUSY: cnt decrements each cycle; at cnt==0 -> RUN next edge. mdu_busy is 1 for exactly MDU_LATENCY cycles after the start edge.
  - mdu_start_execute while BUSY is ignored; state and cnt are unchanged.
- stall_cycles increments on each edge where stall=1. It holds at all-ones, with no wrap.
- Reset (rst=0 at an edge): FSM->RUN, cnt->0, stall_cycles->0.
- While rst=0, every combinational output is forced to 0 and forward selects to 00. A reset mid-MDU-operation abandons it.

Decomposition:
- defines.v gains `REG_ADDR_W (5), `FWD_NONE 2'b00, `FWD_WB 2'b01, `FWD_MEM 2'b10, and the FSM state codes `MDU_RUN/`MDU_BUSY.
- One natural sub-module: mdu_tracker (FSM, counter, mdu_busy output).
- Hazard/forward logic and the perf counter stay in hazard_ctrl.

Test Plan:
- Load-use: mem_to_reg_execute=1, wa_execute=8, rs_decode=8 -> stall_fetch=stall_decode=flush_execute=1, flush_decode=0; stall_cycles goes 0->1. Repeat with wa_execute=0 -> no stall.
- Forwarding priority: reg_write_memory=1, wa_memory=5; reg_write_writeback=1, wa_writeback=5; rs_execute=5 -> forward_a_execute=10. Drop MEM write -> 01. With rt_execute=0 -> forward_b_execute=00.
- Branch: branch_decode=1, rs_decode=9, reg_write_execute=1, wa_execute=9, pc_src_decode=1 -> stall=1, flush_decode=0. Next cycle wa_execute=3, reg_write_memory=1, wa_memory=9 -> stall=0, flush_decode=1, forward_a_decode=1.
- MDU: MDU_LATENCY=4, start pulse at edge 0 -> mdu_busy=1 after edges 0..3, 0 after edge 4. mdu_use_decode=1 during busy -> stall. Second start during busy leaves release at edge 4.
- Reset mid-op: rst=0 at edge 2 of an MDU op -> mdu_busy=0, stall_cycles=0, all outputs 0 while rst=0.
- Saturation: force 2^WIDTH-1 stall cycles (or small WIDTH=4 build, 16 stall cycles) -> stall_cycles holds at all-ones.
